sensor_packet_framer: RTL and testbench
=======================================

# sensor_packet_framer

Drains sensor bytes from the `sync_fifo` read port and emits them as framed byte packets on a valid/ready stream toward the host link. A frame is SYNC, ID, LEN, PAYLOAD..., CSUM. A frame starts when a full payload is buffered, or after an idle timeout flushes a partial payload. The block sits between the sensor-side FIFO and the serial/host transmitter; it is the only reader of that FIFO.

## Interface
Parameters:
- `DEPTH`, 16: depth of the attached FIFO; sets the `fifo_count` width to $clog2(DEPTH+1).
- `PAYLOAD_LEN`, 4: nominal payload bytes per frame, range 1..DEPTH.
- `TIMEOUT`, 64: idle cycles, with the FIFO non-empty but below `PAYLOAD_LEN`, before a partial flush. Must be ≥1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sensor_id` in 8: source ID; sampled on the frame-start edge.
- `fifo_rd_en` out 1: FIFO read strobe.
- `fifo_rd_data` in 8: FIFO read data; valid in the cycle after the edge that samples `fifo_rd_en`.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_count` in $clog2(DEPTH+1): FIFO occupancy.
- `out_data` out 8: framed byte, registered.
- `out_valid` out 1: `out_data` is valid, registered.
- `out_ready` in 1: downstream accepts; a transfer happens on an edge where `out_valid && out_ready`.
- `busy` out 1: a frame is in progress (state ≠ IDLE).

## Operation
- States: IDLE, SYNC, ID, LEN, FETCH, WAIT, PAY, CSUM.
- Frame start, evaluated in IDLE every cycle:
  - `fifo_count >= PAYLOAD_LEN`: `len` = `PAYLOAD_LEN`.
  - Otherwise, `!fifo_empty` and the timer equals TIMEOUT-1: `len` = `fifo_count`.
  - The start edge also latches `sensor_id` and clears the checksum.
- Timer behaviour:
  - Increments in IDLE while `!fifo_empty && fifo_count < PAYLOAD_LEN`.
  - Clears when the FIFO is empty, on frame start, and outside IDLE.
- Transitions:
  - IDLE→SYNC on start.
  - SYNC→ID, ID→LEN, and PAY→FETCH or CSUM, each on transfer.
  - LEN→FETCH on transfer.
  - FETCH→WAIT after one cycle.
  - WAIT→PAY after one cycle; `fifo_rd_data` is captured into `out_data`.
  - PAY goes to CSUM when the payload index reaches `len`, else to FETCH.
  - CSUM→IDLE on transfer.
- Output bytes:
  - SYNC = 8'hA5.
  - ID = latched id.
  - LEN = `len`.
  - CSUM = XOR of ID, LEN and all payload bytes.
- `fifo_rd_en` is high for exactly the FETCH cycle, once per payload byte.
  - If `fifo_empty` is high in FETCH (defensive case), stay in FETCH with `fifo_rd_en` low.
- `len` is frozen for the whole frame; FIFO writes during a frame do not alter it.
- `out_valid` is low in IDLE, FETCH and WAIT. Once asserted, `out_data` is held stable until transferred; no retraction.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `fifo_rd_en`=0, `busy`=0, state IDLE, timer 0, checksum 0.
- Reset takes effect immediately and asynchronously, even mid-frame. The partial frame is abandoned; receivers resync on 8'hA5.
- Start decision edge → `out_valid`=1 with 8'hA5 in the next cycle.
- Header/CSUM byte: the next byte is valid in the cycle after its predecessor's transfer.
- Payload byte: the previous transfer edge leads to FETCH (1 cycle), then WAIT (1 cycle), then valid. This gives a 2-cycle `out_valid` gap per payload byte.
- With `out_ready` held high, a frame of N payload bytes occupies 4+3N cycles from the first `out_valid`.
- Back-to-back frames: CSUM transfer → IDLE (1 cycle) → next SYNC if the start condition holds.
- Timeout: a partial frame starts on the TIMEOUT-th consecutive qualifying IDLE cycle.
- `out_ready` low stalls the current state indefinitely; no FIFO reads occur while stalled.

## Structure
- Shared package `iot_frame_pkg`:
  - `SYNC_BYTE` = 8'hA5.
  - `framer_state_t` enum.
  - `FRAME_OVERHEAD` = 4.
- No sub-module: the timer, index counter and checksum are inline in one module of about 200 lines.

## Test plan
- Reset: hold `rst` high mid-activity → all outputs 0, `busy`=0.
- Full frame: preload 00,01,02,03; `sensor_id`=03; `out_ready`=1 → stream A5,03,04,00,01,02,03,07; exactly 4 `fifo_rd_en` pulses; 16 cycles from the first valid.
- Backpressure: `out_ready`=0 for 5 cycles while LEN is presented → `out_data` stays 04, `out_valid` stays 1, no `fifo_rd_en`; the stream resumes intact.
- Timeout flush: TIMEOUT=64; write a single AA → after 64 idle cycles, stream A5,03,01,AA,A8.
- Two frames: preload 8 bytes 10..17 → two back-to-back LEN=4 frames with CSUM 07 and 07. The checksum is sensor_id ^ 04 ^ XOR of the 4 payload bytes; 03^04^10^11^12^13 = 07 and 03^04^14^15^16^17 = 07. One IDLE cycle separates the frames.
- Reset mid-payload: assert `rst` in WAIT of the second payload byte → outputs 0 at once. After release, a fresh frame starts with A5 from the remaining FIFO contents.

Source files
------------

// File: rtl/iot_frame_pkg.sv
// Shared constants and state encoding for the sensor packet framer.
// Frame layout on the wire: SYNC, ID, LEN, PAYLOAD..., CSUM.
package iot_frame_pkg;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int         FRAME_OVERHEAD = 4;   // SYNC + ID + LEN + CSUM

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_ID    = 3'd2,
    ST_LEN   = 3'd3,
    ST_FETCH = 3'd4,
    ST_WAIT  = 3'd5,
    ST_PAY   = 3'd6,
    ST_CSUM  = 3'd7
  } framer_state_t;

endpackage

// File: rtl/sensor_packet_framer.sv
// Purpose: drains the sensor FIFO and emits SYNC/ID/LEN/PAYLOAD/CSUM byte frames.
// Latency: start edge -> SYNC valid next cycle; each payload byte costs FETCH+WAIT before it is valid.
// Backpressure: out_ready low holds the current byte and state; no FIFO reads happen while stalled.
module sensor_packet_framer
  import iot_frame_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int PAYLOAD_LEN = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   sensor_id,
  output logic                         fifo_rd_en,
  input  logic [7:0]                   fifo_rd_data,
  input  logic                         fifo_empty,
  input  logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic [7:0]                   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] PLEN_C  = CW'(PAYLOAD_LEN);
  localparam logic [TW-1:0] TLAST_C = TW'(TIMEOUT - 1);

  framer_state_t r_state;
  framer_state_t w_next;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_len;
  logic [7:0]    r_idx;
  logic [7:0]    r_id;
  logic [7:0]    r_csum;

  logic          w_xfer;
  logic          w_full;
  logic          w_tmo;
  logic          w_start;
  logic [7:0]    w_start_len;
  logic          w_rd_en;

  assign w_xfer      = out_valid && out_ready;
  assign w_full      = (fifo_count >= PLEN_C);
  assign w_tmo       = !fifo_empty && (r_timer == TLAST_C);
  assign w_start     = (r_state == ST_IDLE) && (w_full || w_tmo);
  // A full payload always wins over a timeout flush; a flush takes whatever is buffered.
  assign w_start_len = w_full ? 8'(PAYLOAD_LEN) : 8'(fifo_count);

  assign fifo_rd_en  = w_rd_en;
  assign busy        = (r_state != ST_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and the FIFO read strobe (high only in a FETCH cycle with data available).
  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_start) w_next = ST_SYNC;
      ST_SYNC:  if (w_xfer)  w_next = ST_ID;
      ST_ID:    if (w_xfer)  w_next = ST_LEN;
      ST_LEN:   if (w_xfer)  w_next = ST_FETCH;
      ST_FETCH: begin
        // An empty FIFO here should not happen (len never exceeds occupancy); just wait.
        if (!fifo_empty) begin
          w_rd_en = 1'b1;
          w_next  = ST_WAIT;
        end
      end
      ST_WAIT:  w_next = ST_PAY;
      ST_PAY:   if (w_xfer) w_next = (r_idx == r_len) ? ST_CSUM : ST_FETCH;
      ST_CSUM:  if (w_xfer) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Idle timer: counts cycles with a partial payload waiting; cleared otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (r_state != ST_IDLE || w_start || fifo_empty || w_full) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Output byte register, frame context (id, len, index) and running checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      r_len     <= 8'h00;
      r_idx     <= 8'h00;
      r_id      <= 8'h00;
      r_csum    <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_id      <= sensor_id;
            r_len     <= w_start_len;
            r_idx     <= 8'h00;
            r_csum    <= 8'h00;
            out_data  <= SYNC_BYTE;
            out_valid <= 1'b1;
          end
        end
        ST_SYNC: begin
          if (w_xfer) begin
            out_data <= r_id;
            r_csum   <= r_csum ^ r_id;
          end
        end
        ST_ID: begin
          if (w_xfer) begin
            out_data <= r_len;
            r_csum   <= r_csum ^ r_len;
          end
        end
        ST_LEN: begin
          if (w_xfer) out_valid <= 1'b0;
        end
        ST_WAIT: begin
          // Read data from the FETCH strobe is valid in this cycle.
          out_data  <= fifo_rd_data;
          out_valid <= 1'b1;
          r_csum    <= r_csum ^ fifo_rd_data;
          r_idx     <= r_idx + 8'd1;
        end
        ST_PAY: begin
          if (w_xfer) begin
            if (r_idx == r_len) out_data <= r_csum;
            else                out_valid <= 1'b0;
          end
        end
        ST_CSUM: begin
          if (w_xfer) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_packet_framer.sv
// Self-checking bench for sensor_packet_framer with a queue-based FIFO model
// and a byte scoreboard filled when FIFO contents and frames are scheduled.
module tb_sensor_packet_framer;

  localparam int DEPTH       = 16;
  localparam int PAYLOAD_LEN = 4;
  localparam int TIMEOUT     = 64;
  localparam int CW          = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    sensor_id = 8'h03;
  logic          fifo_rd_en;
  logic [7:0]    fifo_rd_data = 8'h00;
  logic          fifo_empty = 1'b1;
  logic [CW-1:0] fifo_count = '0;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;

  sensor_packet_framer #(
    .DEPTH(DEPTH), .PAYLOAD_LEN(PAYLOAD_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .sensor_id(sensor_id),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FIFO model: registered read data one cycle after the strobe edge.
  logic [7:0] fq[$];
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
    fifo_count <= CW'(fq.size());
    fifo_empty <= (fq.size() == 0);
  end

  // Scoreboard entries: {last, first, byte}.
  logic [9:0] sb_q[$];
  int cyc = 0;
  int rd_cnt = 0;
  int t_first = 0;
  int t_last = 0;
  int frame_cycles = 0;
  int frame_gap = 0;
  logic stall_prev = 1'b0;
  logic [7:0] stall_dat = 8'h00;

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [9:0] e;
    cyc++;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (fifo_rd_en) rd_cnt++;
      if (stall_prev) begin
        check("hold_vld", 32'(out_valid), 32'd1);
        check("hold_dat", 32'(out_data), 32'(stall_dat));
        check("stall_rd", 32'(fifo_rd_en), 32'd0);
      end
      stall_prev = out_valid && !out_ready;
      stall_dat  = out_data;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("extra_xfer", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("byte", 32'(out_data), 32'(e[7:0]));
          if (e[8]) begin
            frame_gap = cyc - t_last;
            t_first   = cyc;
          end
          if (e[9]) begin
            frame_cycles = cyc - t_first + 1;
            t_last       = cyc;
          end
        end
      end
    end
  end

  task automatic fifo_write(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
  endtask

  task automatic expect_frame(input logic [7:0] id, input logic [7:0] base, input int n);
    logic [7:0] cs;
    logic [7:0] b;
    cs = id ^ 8'(n);
    sb_q.push_back({2'b01, 8'hA5});
    sb_q.push_back({2'b00, id});
    sb_q.push_back({2'b00, 8'(n)});
    for (int i = 0; i < n; i++) begin
      b  = base + 8'(i);
      cs = cs ^ b;
      sb_q.push_back({2'b00, b});
    end
    sb_q.push_back({2'b10, cs});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (sb_q.size() == 0 && !busy && fq.size() == 0) done = 1'b1;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int rd_base;
    int edges;
    logic hit;

    // Reset state
    repeat (3) step();
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_dat", 32'(out_data), 32'd0);
    check("rst_rd", 32'(fifo_rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // Full frame, out_ready held high
    rd_base = rd_cnt;
    expect_frame(8'h03, 8'h00, 4);
    fifo_write(8'h00, 4);
    wait_drain("drain_full", 500);
    check("full_rd_pulses", 32'(rd_cnt - rd_base), 32'd4);
    check("full_cycles", 32'(frame_cycles), 32'd16);

    // Backpressure while LEN is presented
    expect_frame(8'h03, 8'h20, 4);
    fifo_write(8'h20, 4);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step();
      if (out_valid && out_data == 8'h04) hit = 1'b1;
    end
    check("bp_found_len", 32'(hit), 32'd1);
    out_ready = 1'b0;
    rd_base = rd_cnt;
    repeat (5) step();
    check("bp_rd", 32'(rd_cnt - rd_base), 32'd0);
    check("bp_dat", 32'(out_data), 32'h04);
    check("bp_vld", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_drain("drain_bp", 500);

    // Timeout flush of a single byte
    expect_frame(8'h03, 8'hAA, 1);
    fifo_write(8'hAA, 1);
    edges = 0;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      step();
      edges++;
      if (out_valid) hit = 1'b1;
    end
    check("tmo_edges", 32'(edges), 32'(TIMEOUT + 1));
    wait_drain("drain_tmo", 500);

    // Two back-to-back frames
    rd_base = rd_cnt;
    expect_frame(8'h03, 8'h10, 4);
    expect_frame(8'h03, 8'h14, 4);
    fifo_write(8'h10, 8);
    wait_drain("drain_two", 800);
    check("two_rd_pulses", 32'(rd_cnt - rd_base), 32'd8);
    check("two_gap", 32'(frame_gap), 32'd2);
    check("two_cycles", 32'(frame_cycles), 32'd16);

    // Reset during WAIT of the second payload byte
    expect_frame(8'h03, 8'h30, 4);
    fifo_write(8'h30, 8);
    rd_base = rd_cnt;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step();
      if (rd_cnt - rd_base == 2 && !fifo_rd_en && !out_valid && busy) hit = 1'b1;
    end
    check("mid_found_wait", 32'(hit), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_vld", 32'(out_valid), 32'd0);
    check("mid_rst_dat", 32'(out_data), 32'd0);
    check("mid_rst_rd", 32'(fifo_rd_en), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    sb_q.delete();
    expect_frame(8'h03, 8'h32, 4);
    expect_frame(8'h03, 8'h36, 2);
    repeat (2) step();
    rst = 1'b0;
    wait_drain("drain_after_rst", 1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
